// File: rtl/dp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dp_ram_pkg
// Brief   : Shared constants, types and helpers for the dp_ram storage block.
//           Build option DP_RAM_BYPASS_EN (see dp_ram.sv) does not alter
//           anything in this package.
// Revision: 1.0 - initial release
// ============================================================================
package dp_ram_pkg;

    // Default geometry used by the channel FIFOs.
    localparam int DP_RAM_ADDR_WIDTH = 3;
    localparam int DP_RAM_DATA_WIDTH = 32;

    // One storage word at the default data width.
    typedef logic [DP_RAM_DATA_WIDTH-1:0] dp_ram_word_t;

    // Value presented on output_data while reset is asserted.
    localparam dp_ram_word_t c_dp_ram_reset_word = '0;

    // True when an address selects an implemented word. Both operands are
    // widened to 32 bits so DEPTH = 2^ADDR_WIDTH compares cleanly.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage : dp_ram_pkg
`default_nettype wire

// File: rtl/dp_ram_array.sv
`default_nettype none
// ============================================================================
// Module  : dp_ram_array
// Brief   : Bare storage for dp_ram. One synchronous write port and one
//           combinational read port. No reset: contents are undefined until
//           written. Range checking is done by the parent, but an address
//           that matches no implemented word simply reads as zero.
// Revision: 1.0 - initial release
// ============================================================================
module dp_ram_array
    import dp_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH = DP_RAM_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DP_RAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    // Flattened view of every stored word, used by the read mux.
    logic [DATA_WIDTH-1:0] w_words [DEPTH];

    // Each word is its own register with a decoded write strobe, so the
    // storage has exactly DEPTH entries whatever the address width is.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word;

        // Capture write data when this word is addressed.
        always_ff @(posedge clock) begin
            if (write_en && (write_addr == ADDR_WIDTH'(gi))) begin
                r_word <= input_data;
            end
        end

        assign w_words[gi] = r_word;
    end

    // Combinational read of the addressed word; unmatched addresses give 0.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (read_addr == ADDR_WIDTH'(i)) begin
                read_data = w_words[i];
            end
        end
    end

endmodule : dp_ram_array
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module  : dp_ram
// Brief   : Simple dual-port RAM (one write port, one read port, one clock)
//           used as the storage array behind the channel FIFOs. Read data is
//           registered with one cycle of latency and cleared asynchronously
//           by resetn. Out-of-range writes are dropped, out-of-range reads
//           return zero, and writes are suppressed while resetn is low.
//           Build option:
//             DP_RAM_BYPASS_EN  defined   -> write-first on a same-address
//                                            read/write collision
//                               undefined -> read-old (pre-write contents)
// Revision: 1.0 - initial release
// ============================================================================
module dp_ram
    import dp_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH = DP_RAM_ADDR_WIDTH,
    parameter int          DATA_WIDTH = DP_RAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data
);

    // Reset value of the read register at this instance's data width.
    localparam logic [DATA_WIDTH-1:0] c_reset_data = DATA_WIDTH'(c_dp_ram_reset_word);

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_array_wr_en;
    logic [DATA_WIDTH-1:0] w_array_rd_data;
    logic [DATA_WIDTH-1:0] w_next_data;
    logic [DATA_WIDTH-1:0] r_output_data;

    // Address qualification. A write is committed only when in range and
    // the block is out of reset; the array itself has no reset, so holding
    // resetn low must gate the strobe here to keep memory untouched.
    assign w_wr_in_range = addr_in_range(32'(write_addr), DEPTH);
    assign w_rd_in_range = addr_in_range(32'(read_addr), DEPTH);
    assign w_array_wr_en = write_en && w_wr_in_range && resetn;

    dp_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock      (clock),
        .write_en   (w_array_wr_en),
        .write_addr (write_addr),
        .input_data (input_data),
        .read_addr  (read_addr),
        .read_data  (w_array_rd_data)
    );

`ifdef DP_RAM_BYPASS_EN
    logic w_collision;

    // Same-address read and committed write on this edge: forward the
    // incoming word so the reader sees the new value immediately.
    assign w_collision = w_array_wr_en && w_rd_in_range && (read_addr == write_addr);

    // Select forwarded write data, stored word, or zero for a bad address.
    always_comb begin
        w_next_data = c_reset_data;
        if (w_collision) begin
            w_next_data = input_data;
        end else if (w_rd_in_range) begin
            w_next_data = w_array_rd_data;
        end
    end
`else
    // Read-old: the array read is combinational from the current contents,
    // so a colliding write only becomes visible on the following read.
    always_comb begin
        w_next_data = c_reset_data;
        if (w_rd_in_range) begin
            w_next_data = w_array_rd_data;
        end
    end
`endif

    // Registered read data; cleared immediately whenever resetn drops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_output_data <= c_reset_data;
        end else begin
            r_output_data <= w_next_data;
        end
    end

    assign output_data = r_output_data;

endmodule : dp_ram
`default_nettype wire

// File: tb/tb_dp_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_dp_ram
// Brief   : Self-checking bench for dp_ram. Drives a full-depth instance
//           (DEPTH = 8) and a FIFO-style instance (DEPTH = 6) with identical
//           stimulus and compares both against a behavioural memory model.
//           Honours DP_RAM_BYPASS_EN for the collision expectation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dp_ram;

`ifdef DP_RAM_BYPASS_EN
    localparam bit c_write_first = 1'b1;
`else
    localparam bit c_write_first = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic        write_en;
    logic [2:0]  write_addr;
    logic [2:0]  read_addr;
    logic [31:0] input_data;
    logic [31:0] out_full;
    logic [31:0] out_six;

    int total = 0;
    int bad   = 0;

    // Model state: per instance, the stored words and whether each was written.
    logic [31:0] model_mem   [2][8];
    bit          model_valid [2][8];
    int          model_depth [2] = '{8, 6};

    dp_ram #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8)) u_dut_full (
        .clock       (clock),
        .resetn      (resetn),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .read_addr   (read_addr),
        .input_data  (input_data),
        .output_data (out_full)
    );

    dp_ram #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(6)) u_dut_six (
        .clock       (clock),
        .resetn      (resetn),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .read_addr   (read_addr),
        .input_data  (input_data),
        .output_data (out_six)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, predict the registered output
    // from the model at the edge, update the model, then compare just after.
    task automatic cyc(input logic rn, input logic we, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [31:0] d,
                       input string tag);
        logic [31:0] exp_v [2];
        bit          known [2];
        @(negedge clock);
        resetn     = rn;
        write_en   = we;
        write_addr = wa;
        read_addr  = ra;
        input_data = d;
        @(posedge clock);
        for (int u = 0; u < 2; u++) begin
            if (!rn) begin
                exp_v[u] = 32'h0;
                known[u] = 1'b1;
            end else if (int'(ra) >= model_depth[u]) begin
                exp_v[u] = 32'h0;
                known[u] = 1'b1;
            end else if (c_write_first && we && (wa == ra)) begin
                exp_v[u] = d;
                known[u] = 1'b1;
            end else begin
                exp_v[u] = model_mem[u][ra];
                known[u] = model_valid[u][ra];
            end
            if (rn && we && (int'(wa) < model_depth[u])) begin
                model_mem[u][wa]   = d;
                model_valid[u][wa] = 1'b1;
            end
        end
        #1;
        if (known[0]) check({tag, "/d8"}, out_full, exp_v[0]);
        if (known[1]) check({tag, "/d6"}, out_six,  exp_v[1]);
    endtask

    initial begin
        for (int u = 0; u < 2; u++)
            for (int a = 0; a < 8; a++) begin
                model_mem[u][a]   = 32'h0;
                model_valid[u][a] = 1'b0;
            end

        resetn     = 1'b0;
        write_en   = 1'b0;
        write_addr = 3'd0;
        read_addr  = 3'd0;
        input_data = 32'h0;

        // Reset held for three cycles: output stays zero.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 3'd0, 3'd0, 32'h0, "reset");

        // Release: first sample of unwritten mem[0] is don't-care.
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, "release");

        // Write then read back with one-cycle latency.
        cyc(1'b1, 1'b1, 3'd2, 3'd0, 32'hDEADBEEF, "wr2");
        cyc(1'b1, 1'b0, 3'd0, 3'd2, 32'h0, "rd2");

        // Fill every address, then sweep reads back to back.
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 1'b1, 3'(k), 3'd0, 32'h100 + 32'(k), "fill");
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 1'b0, 3'd0, 3'(k), 32'h0, "sweep");

        // Collision at address 5.
        cyc(1'b1, 1'b1, 3'd5, 3'd0, 32'h11, "coll_setup");
        cyc(1'b1, 1'b1, 3'd5, 3'd5, 32'h22, "coll");
        cyc(1'b1, 1'b0, 3'd0, 3'd5, 32'h0, "coll_after");

        // Async reset mid-stream while output holds 0x107.
        cyc(1'b1, 1'b0, 3'd0, 3'd7, 32'h0, "rd7");
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst/d8", out_full, 32'h0);
        check("async_rst/d6", out_six,  32'h0);
        cyc(1'b0, 1'b1, 3'd7, 3'd7, 32'h00000BAD, "rst_wr");
        cyc(1'b0, 1'b0, 3'd0, 3'd7, 32'h0, "rst_hold");
        cyc(1'b1, 1'b0, 3'd0, 3'd7, 32'h0, "retained");

        // Address 6 lies beyond the six-word instance.
        cyc(1'b1, 1'b1, 3'd6, 3'd0, 32'hFF, "wr6");
        cyc(1'b1, 1'b0, 3'd0, 3'd6, 32'h0, "rd6");

        // Randomised traffic, including collisions and out-of-range access.
        for (int k = 0; k < 300; k++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 32'($urandom), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dp_ram
`default_nettype wire
